debug_nibble_scanner: RTL
=========================

# debug_nibble_scanner

Display-side stage between the CPU's 32-bit debug output and the two seven-segment `digseg_driver` instances. It snapshots the debug word at a human-readable rate and presents one selectable byte as two nibbles. A debounced push-button selects the byte (page). A second button freezes or unfreezes the snapshot. An optional auto-scroll steps through the pages without user input.

## Interface

Parameters:
- `REFRESH_CYCLES`, default 5_000_000: snapshot period in clocks (0.1 s at 50 MHz); must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 500_000: input-stable time required before a button level is accepted; must be ≥ 2.
- `AUTOSCROLL_CYCLES`, default 100_000_000: auto-scroll period; only used with `DBG_AUTOSCROLL_EN`.

Ports:
- `clk` input 1: the single clock. All state is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `debug_in` input 32: CPU debug word; asynchronous to nothing, sampled only on a refresh tick.
- `btn_next` input 1: raw active-high button that advances the page.
- `btn_freeze` input 1: raw active-high button that toggles freeze.
- `nib_lo` output 4: low nibble of the selected byte, to segdisp0's driver.
- `nib_hi` output 4: high nibble of the selected byte, to segdisp1's driver.
- `page` output 2: selected byte index (0 = bits 7:0 … 3 = bits 31:24).
- `frozen` output 1: 1 while snapshot updates are suppressed.

## Operation

- **Reset** (`rst`=1 at an edge) sets the following; every output is therefore 0 the cycle after reset:
  - snapshot = 0, `page` = 0, `frozen` = 0, `nib_lo` = `nib_hi` = 0;
  - all counters = 0, debouncer stable levels = 0, synchronizers = 0.
- **Refresh counter:**
  - Increments every cycle.
  - While it equals `REFRESH_CYCLES`-1, `tick`=1, and the counter wraps to 0 on the next edge.
  - It runs regardless of `frozen`.
- **Snapshot:** on an edge with `tick`=1 and `frozen`=0, snapshot ← `debug_in`. Otherwise it holds.
- **Debounce** (per button):
  - The raw input passes through a 2-FF synchronizer.
  - If the synchronized value ≠ the stable level, the counter increments. When it reaches `DEBOUNCE_CYCLES`-1, stable ← synchronized value and the counter clears.
  - If the synchronized value = the stable level, the counter clears.
  - A one-cycle `press` pulse fires on a 0→1 transition of the stable level. Releases produce no pulse.
- **Page select:**
  - A `next` press sets `page` ← `page`+1, modulo 4 (3 wraps to 0).
  - A `freeze` press sets `frozen` ← ~`frozen`.
- **Output register:** `nib_lo` ← snapshot[8·page+3 : 8·page] and `nib_hi` ← snapshot[8·page+7 : 8·page+4], both computed from the current registered snapshot and `page`.
- **Simultaneous events:**
  - A `next` press and an auto-scroll tick in the same cycle advance `page` by exactly 1, and the auto-scroll counter restarts from 0.
  - A `freeze` press and `tick` in the same cycle: the snapshot obeys the pre-toggle `frozen` value.
- **Reset mid-operation:** reset overrides everything in that cycle, including pending debounce counts, a partially elapsed refresh period, and a held button. A button still held after reset must be re-qualified through a full debounce before it produces a press.

## Timing

- Snapshot latency: `debug_in` captured at edge E appears on `nib_*` after edge E+1.
- Page latency: a `press` pulse at edge P updates `page` at P, and `nib_*` reflect the new page at P+1.
- Button to press latency: 2 synchronizer cycles + `DEBOUNCE_CYCLES` stable cycles.
- First tick after reset release: during cycle `REFRESH_CYCLES`-1, counting from cycle 0 as the first non-reset cycle.
- There are no handshakes. Consumers treat `nib_*` as static levels.

## Configuration

- `DBG_AUTOSCROLL_EN` defined:
  - A counter of width $clog2(`AUTOSCROLL_CYCLES`) increments each cycle.
  - At `AUTOSCROLL_CYCLES`-1 it wraps and advances `page` as if `next` were pressed.
  - It is suppressed while `frozen`=1; the counter holds its value while frozen.
  - Manual `next` still works and restarts the counter.
- Undefined: no auto-scroll logic is present, and `page` changes only on `next` presses.

## Structure

- Shared package `dbg_pkg` holds:
  - the `page_t` 2-bit type;
  - `DBG_PAGES` = 4;
  - the default period constants above.
- Sub-module `btn_debounce` (synchronizer + debounce counter + rising-edge pulse; parameter `DEBOUNCE_CYCLES`) is instantiated twice.
- All remaining logic lives in the top.

## Test plan

Bench parameters: `REFRESH_CYCLES`=4, `DEBOUNCE_CYCLES`=3, `AUTOSCROLL_CYCLES`=16.

1. Reset, then `debug_in`=32'hA5C3_1E7F held → after the first tick and one further edge, `nib_hi`/`nib_lo` = 7/F and `page`=0. All outputs read 0 before that point.
2. Press `btn_next` high for 10 cycles, three times → `page` steps 1, 2, 3 and nibbles read 1/E, C/3, A/5. A fourth press wraps to `page`=0.
3. `btn_next` glitch high for 2 cycles, then low → no page change. Glitch at 1-cycle spacing for 20 cycles → no change.
4. Press `btn_freeze`, then change `debug_in` to 32'h0000_0000 across several ticks → `frozen`=1 and nibbles unchanged. Press again → `frozen`=0, and the nibbles go to 0 after the next tick + 1.
5. Assert `rst` while `btn_next` is held mid-debounce and `page`=2 → `page`=0, `frozen`=0, nibbles 0. A continued hold yields exactly one press after full re-qualification.
6. With `DBG_AUTOSCROLL_EN` defined: `page` advances every 16 cycles and stops while frozen. A manual press landing on an auto-scroll cycle advances `page` by 1, not 2.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared types and default periods for the debug nibble scanner.
package dbg_pkg;

    typedef logic [1:0] page_t;

    localparam int DBG_PAGES                = 4;
    localparam int DBG_REFRESH_CYCLES_DEF   = 5_000_000;
    localparam int DBG_DEBOUNCE_CYCLES_DEF  = 500_000;
    localparam int DBG_AUTOSCROLL_CYCLES_DEF = 100_000_000;

    function automatic logic [7:0] sel_byte(input logic [31:0] w, input page_t p);
        logic [7:0] b;
        case (p)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/debug_nibble_scanner_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, one-cycle press pulse
// on each accepted 0->1 transition of the debounced level.
module btn_debounce
    import dbg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DBG_DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // Counter only runs while the synchronized input disagrees with the
    // accepted level; any agreement restarts qualification from zero.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) stable_d = sync2_q;
            else                   cnt_d    = cnt_q + 1'b1;
        end
        press_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/debug_nibble_scanner.sv
// Snapshots the 32-bit debug word periodically and shows one selectable byte as
// two nibbles. Optional auto-scroll is enabled with DBG_AUTOSCROLL_EN.
module debug_nibble_scanner
    import dbg_pkg::*;
#(
    parameter int REFRESH_CYCLES    = DBG_REFRESH_CYCLES_DEF,
    parameter int DEBOUNCE_CYCLES   = DBG_DEBOUNCE_CYCLES_DEF,
    parameter int AUTOSCROLL_CYCLES = DBG_AUTOSCROLL_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] debug_in,
    input  logic        btn_next,
    input  logic        btn_freeze,
    output logic [3:0]  nib_lo,
    output logic [3:0]  nib_hi,
    output page_t       page,
    output logic        frozen
);

    localparam int RW = $clog2(REFRESH_CYCLES);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

    logic [RW-1:0] refresh_q, refresh_d;
    logic [31:0]   snap_q, snap_d;
    page_t         page_q, page_d;
    logic          frozen_q, frozen_d;
    logic [3:0]    nib_lo_q, nib_lo_d, nib_hi_q, nib_hi_d;
    logic [7:0]    sel;
    logic          tick, next_press, frz_press, as_tick;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk_i(clk), .rst_i(rst), .btn_i(btn_next), .press_o(next_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_freeze (
        .clk_i(clk), .rst_i(rst), .btn_i(btn_freeze), .press_o(frz_press)
    );

    assign tick = (refresh_q == REF_LAST);

`ifdef DBG_AUTOSCROLL_EN
    localparam int AW = $clog2(AUTOSCROLL_CYCLES);
    localparam logic [AW-1:0] AS_LAST = AW'(AUTOSCROLL_CYCLES - 1);

    logic [AW-1:0] as_q, as_d;

    assign as_tick = !frozen_q && (as_q == AS_LAST);

    // A manual press restarts the period; freezing parks the count in place.
    always_comb begin
        as_d = as_q + 1'b1;
        if (next_press)    as_d = '0;
        else if (frozen_q) as_d = as_q;
        else if (as_tick)  as_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) as_q <= '0;
        else     as_q <= as_d;
    end
`else
    logic unused_as;
    assign unused_as = ^AUTOSCROLL_CYCLES;
    assign as_tick   = 1'b0;
`endif

    // Snapshot gating uses the registered freeze state, so a freeze press that
    // coincides with a tick does not affect that tick's capture.
    always_comb begin
        refresh_d = tick ? '0 : refresh_q + 1'b1;
        snap_d    = (tick && !frozen_q) ? debug_in : snap_q;
        page_d    = (next_press || as_tick) ? page_t'(page_q + 2'd1) : page_q;
        frozen_d  = frozen_q ^ frz_press;
        sel       = sel_byte(snap_q, page_q);
        nib_lo_d  = sel[3:0];
        nib_hi_d  = sel[7:4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_q <= '0;
            snap_q    <= '0;
            page_q    <= '0;
            frozen_q  <= 1'b0;
            nib_lo_q  <= '0;
            nib_hi_q  <= '0;
        end else begin
            refresh_q <= refresh_d;
            snap_q    <= snap_d;
            page_q    <= page_d;
            frozen_q  <= frozen_d;
            nib_lo_q  <= nib_lo_d;
            nib_hi_q  <= nib_hi_d;
        end
    end

    assign nib_lo = nib_lo_q;
    assign nib_hi = nib_hi_q;
    assign page   = page_q;
    assign frozen = frozen_q;

endmodule
